// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of a slow, asynchronous square wave in
// units of clkin cycles. The input is synchronised, edge-detected, and a
// free-running counter is restarted on every detected rising edge. On each
// rising edge after the first, the elapsed count is published as `period`
// together with the high time latched at the intervening falling edge.
// If no rising edge arrives within TIMEOUT cycles the measurement is
// abandoned and the block returns to idle, waiting to be re-armed.
//
// Parameters:
//   CNT_W    width of the cycle counter and of period / high_time
//   TIMEOUT  cycles without a rising edge (while measuring) before giving up;
//            2 <= TIMEOUT <= 2**CNT_W - 1
//
// Ports:
//   clkin      in   system clock, all state changes on its rising edge
//   reset      in   synchronous, active-high reset
//   sig_in     in   measured signal, asynchronous to clkin
//   period     out  clkin cycles between consecutive detected rising edges
//   high_time  out  clkin cycles from a rising edge to the next falling edge
//   valid      out  one-cycle pulse, period/high_time updated in that cycle
//   timeout    out  level, set on timeout, cleared by the next valid
// -----------------------------------------------------------------------------
module period_meter #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       MEASURE  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // The TIMEOUT range guarantees cnt never reaches all-ones before being
    // cleared or abandoned, so this increment cannot wrap.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    logic             s1, s2, s3;
    logic             rise, fall;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_lat;

    // ---- synchroniser (s1, s2) and edge-detect delay (s3) ----
    always_ff @(posedge clkin) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // rise and fall come from the same s2/s3 pair, so they are mutually
    // exclusive by construction.
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // ---- measurement counter, high-time latch and result registers ----
    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_lat    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // The first rising edge only arms; there is no previous
                    // edge to measure from.
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                default: begin
                    // fall is latched independently of the timeout check so a
                    // late falling edge on the abandoning cycle is still seen.
                    if (fall) begin
                        hi_lat <= cnt_inc(cnt);
                    end
                    if (rise) begin
                        // A rise on the threshold cycle wins over the timeout.
                        cnt       <= '0;
                        period    <= cnt_inc(cnt);
                        high_time <= hi_lat;
                        valid     <= 1'b1;
                        timeout   <= 1'b0;
                    end else begin
                        cnt <= cnt_inc(cnt);
                        if (cnt == CNT_LAST) begin
                            state   <= IDLE;
                            timeout <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//
// Directed bench for period_meter. Two instances share clkin, reset and
// sig_in: `a` uses the default TIMEOUT for long-period measurements, `b` uses
// TIMEOUT = 50 for the timeout and threshold scenarios. Inputs are driven and
// outputs sampled 1 time unit after each rising clkin edge.
// -----------------------------------------------------------------------------
module tb_period_meter;

    logic        clkin;
    logic        reset;
    logic        sig_in;
    logic [31:0] period_a, high_a, period_b, high_b;
    logic        valid_a, timeout_a, valid_b, timeout_b;

    int errors = 0;
    int checks = 0;

    // Per-test observation state, updated by step()
    int   nv_a, nv_b;
    logic prev_a, prev_b, cons_a, cons_b;

    period_meter #(.CNT_W(32), .TIMEOUT(100000)) dut_a (
        .clkin     (clkin),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period_a),
        .high_time (high_a),
        .valid     (valid_a),
        .timeout   (timeout_a)
    );

    period_meter #(.CNT_W(32), .TIMEOUT(50)) dut_b (
        .clkin     (clkin),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period_b),
        .high_time (high_b),
        .valid     (valid_b),
        .timeout   (timeout_b)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Drive sig_in for the next edge, advance one cycle, record valid activity.
    task automatic step(input logic v);
        sig_in = v;
        @(posedge clkin);
        #1;
        if (valid_a) nv_a++;
        if (valid_b) nv_b++;
        if (valid_a && prev_a) cons_a = 1'b1;
        if (valid_b && prev_b) cons_b = 1'b1;
        prev_a = valid_a;
        prev_b = valid_b;
    endtask

    task automatic clear_obs();
        nv_a = 0; nv_b = 0;
        prev_a = 1'b0; prev_b = 1'b0;
        cons_a = 1'b0; cons_b = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(logic'(i % 2 == 0));
            checks++; if (valid_a !== 1'b0)    begin errors++; $display("FAIL reset_valid cyc%0d: got %0b expected 0", i, valid_a); end
            checks++; if (timeout_a !== 1'b0)  begin errors++; $display("FAIL reset_timeout cyc%0d: got %0b expected 0", i, timeout_a); end
            checks++; if (period_a !== 32'd0)  begin errors++; $display("FAIL reset_period cyc%0d: got %0d expected 0", i, period_a); end
            checks++; if (high_a !== 32'd0)    begin errors++; $display("FAIL reset_high cyc%0d: got %0d expected 0", i, high_a); end
            checks++; if (timeout_b !== 1'b0)  begin errors++; $display("FAIL reset_timeout_b cyc%0d: got %0b expected 0", i, timeout_b); end
        end
        // sig_in high at release produces the arming rise only
        reset = 1'b0;
        clear_obs();
        for (int i = 0; i < 10; i++) step(1'b1);
        checks++; if (nv_a !== 0)         begin errors++; $display("FAIL reset_arm_no_valid: got %0d valids expected 0", nv_a); end
        checks++; if (period_a !== 32'd0) begin errors++; $display("FAIL reset_arm_period: got %0d expected 0", period_a); end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int j = 0; j < 4 * 5002; j++) begin
            step(logic'((j % 5002) < 2501));
            if (valid_a) begin
                checks++; if (period_a !== 32'd5002) begin errors++; $display("FAIL nominal_period j%0d: got %0d expected 5002", j, period_a); end
                checks++; if (high_a !== 32'd2501)   begin errors++; $display("FAIL nominal_high j%0d: got %0d expected 2501", j, high_a); end
                checks++; if (timeout_a !== 1'b0)    begin errors++; $display("FAIL nominal_timeout j%0d: got %0b expected 0", j, timeout_a); end
            end
        end
        checks++; if (nv_a !== 3) begin errors++; $display("FAIL nominal_count: got %0d valids expected 3", nv_a); end
    endtask

    task automatic test_asymmetric();
        do_reset();
        for (int j = 0; j < 50; j++) begin
            step(logic'((j % 10) < 3));
            if (valid_a) begin
                checks++; if (period_a !== 32'd10) begin errors++; $display("FAIL asym_period j%0d: got %0d expected 10", j, period_a); end
                checks++; if (high_a !== 32'd3)    begin errors++; $display("FAIL asym_high j%0d: got %0d expected 3", j, high_a); end
            end
        end
        checks++; if (nv_a !== 4)     begin errors++; $display("FAIL asym_count: got %0d valids expected 4", nv_a); end
        checks++; if (cons_a !== 1'b0) begin errors++; $display("FAIL asym_pulse_width: got %0b expected 0 (multi-cycle valid)", cons_a); end
    endtask

    task automatic test_min_period();
        do_reset();
        for (int j = 0; j < 24; j++) begin
            step(logic'((j < 20) && (j % 2 == 0)));
            if (valid_a) begin
                checks++; if (period_a !== 32'd2) begin errors++; $display("FAIL minper_period j%0d: got %0d expected 2", j, period_a); end
                checks++; if (high_a !== 32'd1)   begin errors++; $display("FAIL minper_high j%0d: got %0d expected 1", j, high_a); end
            end
        end
        checks++; if (nv_a !== 9)      begin errors++; $display("FAIL minper_count: got %0d valids expected 9", nv_a); end
        checks++; if (cons_a !== 1'b0) begin errors++; $display("FAIL minper_back_to_back: got %0b expected 0", cons_a); end
    endtask

    task automatic test_timeout();
        logic v;
        do_reset();
        for (int j = 0; j < 160; j++) begin
            v = (j < 10) || (j >= 20 && j < 30) || (j >= 90 && j < 100) || (j >= 120 && j < 130);
            step(v);
            if (j == 22) begin
                checks++; if (valid_b !== 1'b1)   begin errors++; $display("FAIL to_first_valid: got %0b expected 1", valid_b); end
                checks++; if (period_b !== 32'd20) begin errors++; $display("FAIL to_first_period: got %0d expected 20", period_b); end
                checks++; if (high_b !== 32'd10)   begin errors++; $display("FAIL to_first_high: got %0d expected 10", high_b); end
            end
            if (j == 71) begin
                checks++; if (timeout_b !== 1'b0) begin errors++; $display("FAIL to_early: got %0b expected 0", timeout_b); end
            end
            if (j == 72) begin
                checks++; if (timeout_b !== 1'b1)  begin errors++; $display("FAIL to_set: got %0b expected 1", timeout_b); end
                checks++; if (period_b !== 32'd20) begin errors++; $display("FAIL to_period_hold: got %0d expected 20", period_b); end
            end
            if (j == 92) begin
                checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL to_rearm_no_valid: got %0b expected 0", valid_b); end
            end
            if (j == 121) begin
                checks++; if (timeout_b !== 1'b1) begin errors++; $display("FAIL to_level_held: got %0b expected 1", timeout_b); end
            end
            if (j == 122) begin
                checks++; if (valid_b !== 1'b1)    begin errors++; $display("FAIL to_second_valid: got %0b expected 1", valid_b); end
                checks++; if (period_b !== 32'd30) begin errors++; $display("FAIL to_second_period: got %0d expected 30", period_b); end
                checks++; if (high_b !== 32'd10)   begin errors++; $display("FAIL to_second_high: got %0d expected 10", high_b); end
                checks++; if (timeout_b !== 1'b0)  begin errors++; $display("FAIL to_cleared: got %0b expected 0", timeout_b); end
            end
        end
        checks++; if (nv_b !== 2) begin errors++; $display("FAIL to_count: got %0d valids expected 2", nv_b); end
    endtask

    task automatic test_threshold_tie();
        do_reset();
        for (int j = 0; j < 60; j++) begin
            step(logic'((j < 10) || (j >= 50 && j < 55)));
            if (j == 52) begin
                checks++; if (valid_b !== 1'b1)    begin errors++; $display("FAIL tie_valid: got %0b expected 1", valid_b); end
                checks++; if (period_b !== 32'd50) begin errors++; $display("FAIL tie_period: got %0d expected 50", period_b); end
                checks++; if (high_b !== 32'd10)   begin errors++; $display("FAIL tie_high: got %0d expected 10", high_b); end
                checks++; if (timeout_b !== 1'b0)  begin errors++; $display("FAIL tie_timeout: got %0b expected 0", timeout_b); end
            end
            if (j == 53) begin
                checks++; if (timeout_b !== 1'b0) begin errors++; $display("FAIL tie_timeout_after: got %0b expected 0", timeout_b); end
            end
        end
        checks++; if (nv_b !== 1) begin errors++; $display("FAIL tie_count: got %0d valids expected 1", nv_b); end
    endtask

    task automatic test_reset_mid();
        int nv_after;
        nv_after = 0;
        do_reset();
        for (int j = 0; j < 320; j++) begin
            reset = (j >= 112 && j < 114);
            step(logic'((j % 100) < 5));
            if (j >= 112 && valid_a) nv_after++;
            if (j == 102) begin
                checks++; if (valid_a !== 1'b1)     begin errors++; $display("FAIL mid_pre_valid: got %0b expected 1", valid_a); end
                checks++; if (period_a !== 32'd100) begin errors++; $display("FAIL mid_pre_period: got %0d expected 100", period_a); end
            end
            if (j == 112 || j == 113) begin
                checks++; if (period_a !== 32'd0) begin errors++; $display("FAIL mid_rst_period j%0d: got %0d expected 0", j, period_a); end
                checks++; if (high_a !== 32'd0)   begin errors++; $display("FAIL mid_rst_high j%0d: got %0d expected 0", j, high_a); end
                checks++; if (valid_a !== 1'b0)   begin errors++; $display("FAIL mid_rst_valid j%0d: got %0b expected 0", j, valid_a); end
            end
            if (j == 302) begin
                checks++; if (valid_a !== 1'b1)     begin errors++; $display("FAIL mid_post_valid: got %0b expected 1", valid_a); end
                checks++; if (period_a !== 32'd100) begin errors++; $display("FAIL mid_post_period: got %0d expected 100", period_a); end
                checks++; if (high_a !== 32'd5)     begin errors++; $display("FAIL mid_post_high: got %0d expected 5", high_a); end
            end
        end
        checks++; if (nv_after !== 1) begin errors++; $display("FAIL mid_post_count: got %0d valids expected 1", nv_after); end
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = 1'b0;
        clear_obs();
        test_reset();
        test_nominal();
        test_asymmetric();
        test_min_period();
        test_timeout();
        test_threshold_tie();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
